conv_layer_ctrl: RTL

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

---
 rtl/conv_ctrl_pkg.sv | 21 ++
 rtl/conv_layer_beat_cnt.sv | 48 ++++
 rtl/conv_layer_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution layer controller: controller states,
// default field widths and the 3x3 kernel size.
package conv_ctrl_pkg;

    localparam int DEF_WIDTH_FEATURE_SIZE = 12;
    localparam int DEF_WIDTH_CHANNEL_NUM  = 10;
    localparam int KERNEL_SIZE            = 3;

    // State encoding kept as plain constants for compatibility with older blocks
    typedef logic [2:0] conv_state_t;

    localparam conv_state_t ST_IDLE  = 3'd0;
    localparam conv_state_t ST_CHECK = 3'd1;
    localparam conv_state_t ST_MUL1  = 3'd2;
    localparam conv_state_t ST_MUL2  = 3'd3;
    localparam conv_state_t ST_LOAD  = 3'd4;
    localparam conv_state_t ST_START = 3'd5;
    localparam conv_state_t ST_RUN   = 3'd6;
    localparam conv_state_t ST_DONE  = 3'd7;

endpackage

// File: rtl/conv_layer_beat_cnt.sv
// Output-beat counter with terminal-count detect and, when
// CONV_LAYER_CTRL_TIMEOUT_EN is defined, a RUN-state stall timer.
module conv_layer_beat_cnt #(
    parameter int CNT_W          = 34,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic             out_fire,
    input  logic [CNT_W-1:0] total,
    output logic             last_beat,
    output logic             timeout_hit
);

    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt <= '0;
        end else if (run && out_fire) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign last_beat = run && out_fire && (beat_cnt == total - CNT_W'(1));

`ifdef CONV_LAYER_CTRL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;

    // Counts idle RUN cycles; the cycle that would bring it to the limit flags the timeout
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            stall_cnt <= '0;
        end else if (run) begin
            stall_cnt <= out_fire ? '0 : stall_cnt + STALL_W'(1);
        end
    end

    assign timeout_hit = run && !out_fire && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer for the convolution datapath: accepts a layer descriptor,
// validates it, computes the expected output-beat total, pulses Next_Reg/Start
// and tracks output beats to Layer_Done. Optional stall timeout under
// CONV_LAYER_CTRL_TIMEOUT_EN.
//
// Handshake: a descriptor transfers on a rising edge where Cfg_Valid and
// Cfg_Ready are both high; Cfg_Ready is high only while idle, so at most one
// layer is ever in flight.
module conv_layer_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int WIDTH_FEATURE_SIZE = DEF_WIDTH_FEATURE_SIZE,
    parameter int WIDTH_CHANNEL_NUM  = DEF_WIDTH_CHANNEL_NUM,
    parameter int TIMEOUT_CYCLES     = 1048576
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Cfg_Valid,
    output logic                          Cfg_Ready,
    input  logic [WIDTH_FEATURE_SIZE-1:0] Cfg_Row_Num,
    input  logic [WIDTH_CHANNEL_NUM-1:0]  Cfg_Channel_In_Num,
    input  logic                          Cfg_Padding,
    input  logic [7:0]                    Cfg_Zero_Point,
    input  logic [2:0]                    Cfg_Zero_Num,
    input  logic                          Cfg_EN_Cin_Select,
    output logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_In_REG,
    output logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
    output logic                          Padding_REG,
    output logic [7:0]                    Zero_Point_REG,
    output logic [2:0]                    Zero_Num_REG,
    output logic                          EN_Cin_Select_REG,
    output logic                          Next_Reg,
    output logic                          Start,
    input  logic                          Out_Fire,
    output logic                          Busy,
    output logic                          Layer_Done,
    output logic                          Cfg_Err,
    output logic                          Timeout_Err,
    output logic [2:0]                    Fsm_State
);

    localparam int CNT_W = 2*WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM;
    localparam int WF    = WIDTH_FEATURE_SIZE;
    localparam int WC    = WIDTH_CHANNEL_NUM;
    localparam int RW    = WF + 2;

    conv_state_t     state;
    conv_state_t     state_nxt;
    logic [RW-1:0]   row_pad_sum;
    logic [WF-1:0]   r_out_c;
    logic            cfg_illegal;
    logic            cfg_accept;
    logic [WF-1:0]   r_out;
    logic [2*WF-1:0] r_sq;
    logic [CNT_W-1:0] total;
    logic            last_beat;
    logic            timeout_hit;

    assign cfg_accept  = Cfg_Valid && (state == ST_IDLE);
    assign row_pad_sum = {2'b00, Row_Num_In_REG} + {{WF{1'b0}}, Padding_REG, 1'b0};
    assign cfg_illegal = (row_pad_sum < RW'(KERNEL_SIZE)) || (Channel_In_Num_REG == '0);
    // A legal descriptor keeps the output row count within WF bits
    assign r_out_c     = WF'(row_pad_sum - RW'(KERNEL_SIZE - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (Cfg_Valid) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = cfg_illegal ? ST_IDLE : ST_MUL1;
            ST_MUL1:  state_nxt = ST_MUL2;
            ST_MUL2:  state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end else if (last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Descriptor fields change only on an accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            Row_Num_In_REG     <= '0;
            Channel_In_Num_REG <= '0;
            Padding_REG        <= 1'b0;
            Zero_Point_REG     <= '0;
            Zero_Num_REG       <= '0;
            EN_Cin_Select_REG  <= 1'b0;
        end else if (cfg_accept) begin
            Row_Num_In_REG     <= Cfg_Row_Num;
            Channel_In_Num_REG <= Cfg_Channel_In_Num;
            Padding_REG        <= Cfg_Padding;
            Zero_Point_REG     <= Cfg_Zero_Point;
            Zero_Num_REG       <= Cfg_Zero_Num;
            EN_Cin_Select_REG  <= Cfg_EN_Cin_Select;
        end
    end

    // Two-stage multiply keeps each stage to a single product
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_sq  <= '0;
            total <= '0;
        end else begin
            if (state == ST_MUL1) begin
                r_out <= r_out_c;
                r_sq  <= {{WF{1'b0}}, r_out_c} * {{WF{1'b0}}, r_out_c};
            end
            if (state == ST_MUL2) begin
                total <= {{WC{1'b0}}, r_sq} * {{2*WF{1'b0}}, Channel_In_Num_REG};
            end
        end
    end

    // A descriptor that passed the check always yields at least one output row
    always_ff @(posedge clk) begin
        if (!rst && state == ST_MUL2) begin
            assert (r_out != '0);
        end
    end

    conv_layer_beat_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_beat_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == ST_START),
        .run         (state == ST_RUN),
        .out_fire    (Out_Fire),
        .total       (total),
        .last_beat   (last_beat),
        .timeout_hit (timeout_hit)
    );

    assign Cfg_Ready   = (state == ST_IDLE);
    assign Busy        = (state != ST_IDLE);
    assign Next_Reg    = (state == ST_LOAD);
    assign Start       = (state == ST_START);
    assign Layer_Done  = (state == ST_DONE);
    assign Cfg_Err     = (state == ST_CHECK) && cfg_illegal;
    assign Timeout_Err = timeout_hit;
    assign Fsm_State   = state;

endmodule
